// File: rtl/arb_out_fifo.sv
// rtl/arb_out_fifo.sv - FWFT output FIFO after the slave arbiter; ARB_OUT_FIFO_OVF_EN adds the ovf_cnt dropped-write counter
module arb_out_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    slvx_mode,
    input  logic [DW-1:0] slvx_data,
    input  logic [7:0]    slvx_proc_val,
    input  logic          slvx_data_valid,
    output logic          fifo_full,
    input  logic          flush,
    output logic [1:0]    out_mode,
    output logic [DW-1:0] out_data,
    output logic [7:0]    out_proc_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fifo_count
`ifdef ARB_OUT_FIFO_OVF_EN
    ,
    output logic [15:0]   ovf_cnt
`endif
);

    localparam int EW = DW + 10;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    // Status flags come only from the registered count, never from inputs.
    assign fifo_full  = (count == FULL_CNT);
    assign out_valid  = (count != '0);
    assign fifo_count = count;

    assign wr_en = slvx_data_valid & ~fifo_full;
    assign rd_en = out_valid & out_ready;

    assign {out_mode, out_proc_val, out_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush) begin
            mem[wr_ptr] <= {slvx_mode, slvx_proc_val, slvx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ARB_OUT_FIFO_OVF_EN
    // Counts drops even in a flush cycle; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (slvx_data_valid && fifo_full && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule
